// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: returns store[pc] after WAIT_CYCLES wait states, holding the
// PC via stallreq while a fetch is in flight and flagging misaligned requests instead of reading.
module inst_fetch_resp #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       addr,
  input  logic              flush,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              misalign,
  output logic              stallreq,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StValid
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;

  logic [31:0] store [Depth];
  logic [31:0] rd_data;
  logic        accept;
  logic        addr_unaligned;

  // Store is deliberately not reset; the loader owns its contents.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      store[ld_addr] <= ld_data;
    end
  end

  // Read sees the pre-edge contents, so a same-edge write returns old data.
  always_comb begin
    rd_data        = store[req_addr_q[ADDR_W+1:2]];
    addr_unaligned = (addr[1:0] != 2'b00);
    accept         = ce && !flush &&
                     ((state_q == StIdle) || ((state_q == StValid) && (addr != req_addr_q)));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      req_addr_q <= '0;
      cnt_q      <= '0;
      inst_q     <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    cnt_d      = cnt_q;
    inst_d     = inst_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;

    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
      end
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end else if (cnt_q == 4'd0) begin
          inst_d  = rd_data;
          valid_d = 1'b1;
          state_d = StValid;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StValid: begin
        if (flush || !ce) begin
          state_d    = StIdle;
          valid_d    = 1'b0;
          misalign_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A new request overrides whatever the current state decided.
    if (accept) begin
      req_addr_d = addr;
      valid_d    = 1'b0;
      misalign_d = 1'b0;
      if (addr_unaligned) begin
        state_d    = StValid;
        inst_d     = '0;
        misalign_d = 1'b1;
        valid_d    = 1'b1;
      end else begin
        cnt_d   = WaitInit;
        state_d = StBusy;
      end
    end
  end

  // Outputs
  always_comb begin
    stallreq   = (state_q == StBusy) || accept;
    inst       = inst_q;
    inst_valid = valid_q;
    misalign   = misalign_q;
  end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: directed scenarios with literal expectations, then random traffic,
// every cycle compared against a transaction-level model of the fetch responder.
module tb_inst_fetch_resp;

  localparam int unsigned AW = 10;
  localparam int unsigned WC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce = 1'b0;
  logic          flush = 1'b0;
  logic          ld_we = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   ld_data = '0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   inst;
  logic          inst_valid;
  logic          misalign;
  logic          stallreq;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: a pending fetch becomes visible at a known cycle; a held result persists until
  // the request is dropped or replaced.
  logic [31:0] m_mem [1024];
  logic        m_waiting, m_holding, m_valid, m_mis;
  logic [31:0] m_req, m_inst;
  int          m_read_cyc;

  always #5 clk = ~clk;

  inst_fetch_resp #(
    .ADDR_W     (AW),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .addr      (addr),
    .flush     (flush),
    .inst      (inst),
    .inst_valid(inst_valid),
    .misalign  (misalign),
    .stallreq  (stallreq),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_waiting = 1'b0;
    m_holding = 1'b0;
    m_valid   = 1'b0;
    m_mis     = 1'b0;
    m_req     = '0;
    m_inst    = '0;
  endtask

  // One clock cycle: drive at the falling edge, compare, then advance the model.
  task automatic step(input logic r, input logic c, input logic [31:0] a, input logic f,
                      input logic we, input logic [AW-1:0] la, input logic [31:0] ld);
    logic acc;
    @(negedge clk);
    rst = r; ce = c; addr = a; flush = f; ld_we = we; ld_addr = la; ld_data = ld;
    #1;
    acc = c && !f && ((!m_waiting && !m_holding) || (m_holding && a != m_req));
    chk("stallreq", 32'(stallreq), 32'(m_waiting || acc));
    chk("inst", inst, m_inst);
    chk("inst_valid", 32'(inst_valid), 32'(m_valid));
    chk("misalign", 32'(misalign), 32'(m_mis));
    if (r) begin
      model_reset();
    end else begin
      if (m_waiting) begin
        if (f) begin
          m_waiting = 1'b0;
          m_valid   = 1'b0;
        end else if (cyc == m_read_cyc) begin
          m_inst    = m_mem[m_req[AW+1:2]];
          m_valid   = 1'b1;
          m_waiting = 1'b0;
          m_holding = 1'b1;
        end
      end else if (m_holding && !acc && (f || !c)) begin
        m_holding = 1'b0;
        m_valid   = 1'b0;
        m_mis     = 1'b0;
      end
      if (acc) begin
        m_req   = a;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        if (a[1:0] != 2'b00) begin
          m_holding = 1'b1;
          m_waiting = 1'b0;
          m_inst    = '0;
          m_mis     = 1'b1;
          m_valid   = 1'b1;
        end else begin
          m_holding  = 1'b0;
          m_waiting  = 1'b1;
          m_read_cyc = cyc + 1 + int'(WC);
        end
      end
    end
    if (we) m_mem[la] = ld;
    cyc++;
  endtask

  task automatic fetch(input logic c, input logic [31:0] a, input logic f);
    step(1'b0, c, a, f, 1'b0, '0, '0);
  endtask

  // Run an aligned fetch for six cycles starting from an idle or foreign-address state.
  task automatic fetch6(input string name, input logic [31:0] a, input logic [31:0] exp_inst,
                        input logic first_valid);
    for (int i = 0; i < 6; i++) begin
      fetch(1'b1, a, 1'b0);
      chk({name, "_stall"}, 32'(stallreq), 32'(i < 4));
      if (i > 0) chk({name, "_valid"}, 32'(inst_valid), 32'(i >= 4));
      else chk({name, "_valid0"}, 32'(inst_valid), 32'(first_valid));
      if (i >= 4) chk({name, "_inst"}, inst, exp_inst);
    end
  endtask

  initial begin
    logic [31:0] cur;
    logic        c, f, we;
    model_reset();

    @(negedge clk);
    #1;
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    chk("rst_stall", 32'(stallreq), 32'h0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);

    for (int k = 0; k < 32; k++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(k), 32'h1000_0000 | 32'(k << 8) | 32'(k));
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, AW'(3), 32'h3402_1100);

    fetch6("t1", 32'h0000_000C, 32'h3402_1100, 1'b0);
    fetch(1'b1, 32'h0000_000C, 1'b0);
    chk("t1_hold_inst", inst, 32'h3402_1100);
    chk("t1_hold_valid", 32'(inst_valid), 32'h1);

    fetch6("t2a", 32'h0000_0000, 32'h1000_0000, 1'b1);
    fetch6("t2b", 32'h0000_0004, 32'h1000_0101, 1'b1);

    fetch(1'b1, 32'h0000_0010, 1'b0);
    chk("t3_accept_stall", 32'(stallreq), 32'h1);
    fetch(1'b1, 32'h0000_0010, 1'b0);
    chk("t3_busy1_valid", 32'(inst_valid), 32'h0);
    fetch(1'b1, 32'h0000_0010, 1'b1);
    chk("t3_flush_stall", 32'(stallreq), 32'h1);
    fetch6("t3", 32'h0000_0020, 32'h1000_0808, 1'b0);

    fetch(1'b1, 32'h0000_0006, 1'b0);
    chk("t4_accept_stall", 32'(stallreq), 32'h1);
    fetch(1'b1, 32'h0000_0006, 1'b0);
    chk("t4_stall", 32'(stallreq), 32'h0);
    chk("t4_misalign", 32'(misalign), 32'h1);
    chk("t4_valid", 32'(inst_valid), 32'h1);
    chk("t4_inst", inst, 32'h0);

    fetch6("t5a", 32'h0000_0008, 32'h1000_0202, 1'b1);
    fetch(1'b1, 32'h0000_0004, 1'b0);
    fetch(1'b1, 32'h0000_0004, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t5_arst_inst", inst, 32'h0);
    chk("t5_arst_valid", 32'(inst_valid), 32'h0);
    chk("t5_arst_misalign", 32'(misalign), 32'h0);
    model_reset();
    step(1'b1, 1'b1, 32'h0000_0008, 1'b0, 1'b0, '0, '0);
    fetch6("t5b", 32'h0000_0008, 32'h1000_0202, 1'b0);

    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 32'h0000_0014, 1'b0, (i == 3), AW'(5), 32'hAAAA_5555);
      if (i >= 4) chk("t6_old_inst", inst, 32'h1000_0505);
    end
    fetch(1'b0, 32'h0000_0014, 1'b0);
    fetch6("t6_new", 32'h0000_0014, 32'hAAAA_5555, 1'b0);

    cur = 32'h0000_0000;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        cur = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2);
        if ($urandom_range(0, 7) == 0) cur = cur | 32'($urandom_range(1, 3));
      end
      c  = ($urandom_range(0, 9) < 8);
      f  = ($urandom_range(0, 15) == 0);
      we = ($urandom_range(0, 7) == 0);
      step(1'b0, c, cur, f, we, AW'($urandom_range(0, 31)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_resp.md
# inst_fetch_resp

Instruction-fetch responder: the memory-side end of the fetch interface driven by the PC generator's `pc`/`ce`. It holds a loadable instruction store and returns the word at the requested PC after a configurable number of wait states. It raises `stallreq` toward the pipeline controller so that `stall[0]` freezes the PC while a fetch is outstanding. A misaligned PC is flagged instead of being read.

## Interface
- `ADDR_W`, 10: word-index width; the store holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, 2: wait states per fetch; legal range 0..15.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high (`RstEnable` = 1'b1).
- `ce` in 1: fetch enable from the PC generator (`ChipEnable` = 1).
- `addr` in 32 (`InstAddrBus`): byte address of the requested instruction.
- `flush` in 1: abandon any in-flight or held fetch (branch/exception redirect).
- `inst` out 32 (`InstBus`): fetched instruction.
- `inst_valid` out 1: `inst` is valid for `req_addr`.
- `misalign` out 1: held request had `addr[1:0]` != 0.
- `stallreq` out 1: combinational stall request to the controller.
- `ld_we` in 1: loader write enable.
- `ld_addr` in ADDR_W: loader word index.
- `ld_data` in 32: loader write data.

## Operation
- Internal registers: `state` ∈ {IDLE, BUSY, VALID}, `req_addr[31:0]`, 4-bit `cnt`, `inst`, `inst_valid`, `misalign`. Store array is not reset.
- accept = `ce`=1 AND `flush`=0 AND (state=IDLE OR (state=VALID AND `addr` != `req_addr`)).
- On accept:
  - `req_addr` <= `addr`, `inst_valid` <= 0, `misalign` <= 0.
  - If `addr[1:0]` != 0: go to VALID with `inst` <= 0 and `misalign` <= 1. No store read.
  - Otherwise: `cnt` <= WAIT_CYCLES and go to BUSY.
- IDLE: `inst_valid` = 0; wait for accept.
- BUSY:
  - `flush`=1 → IDLE with `inst_valid` <= 0.
  - Else if `cnt`=0: `inst` <= store[`req_addr[ADDR_W+1:2]`], `inst_valid` <= 1, go to VALID.
  - Else `cnt` <= `cnt`-1.
  - `ce` and `addr` are ignored in BUSY; the request is already latched.
- VALID:
  - Hold `inst`/`inst_valid`/`misalign` while `ce`=1 and `addr` = `req_addr`.
  - `flush`=1, or `ce`=0 → IDLE with `inst_valid` <= 0 and `misalign` <= 0.
  - New address → accept.
- `stallreq` = (state=BUSY) OR accept.
- Address bits above ADDR_W+1 are ignored; addresses alias modulo 2^(ADDR_W+2).
- Loader: `ld_we`=1 writes store[`ld_addr`] <= `ld_data` at the edge, in any state. A read and a write of the same word at the same edge returns the old data.

## Timing
- Reset value of every output/register:
  - `inst`=0, `inst_valid`=0, `misalign`=0, `req_addr`=0, `cnt`=0, state=IDLE.
  - `stallreq` = accept-term only, i.e. 1 if `ce`=1 right after reset release.
- Reset asserted mid-fetch drops the fetch immediately; no valid is produced.
- Aligned fetch, request present in cycle N:
  - Accepted at the end of N.
  - BUSY during N+1 .. N+1+WAIT_CYCLES.
  - `inst_valid`=1 from cycle N+2+WAIT_CYCLES.
  - `stallreq`=1 for cycles N .. N+1+WAIT_CYCLES (WAIT_CYCLES+2 cycles).
- Misaligned request in cycle N: `misalign`=`inst_valid`=1 from N+1; `stallreq`=1 in N only.
- Simultaneous `flush` and accept condition: flush wins. No accept; `stallreq` follows state only.
- Flush in the last BUSY cycle (`cnt`=0): no valid; the store read is discarded.
- WAIT_CYCLES=0: minimum aligned latency is 2 cycles.

## Test plan
- Reset, then load word 3 = 0x3402_1100. `ce`=1, `addr`=0x0000_000C, WAIT_CYCLES=2 → `stallreq` high 4 cycles, then `inst`=0x3402_1100, `inst_valid`=1, held while `addr` is constant.
- Back-to-back fetches 0x0 then 0x4 (PC held during stall, then advanced) → each word valid after 4 stall cycles; `inst_valid` drops in the cycle the new address is accepted.
- `flush` pulsed in the 2nd BUSY cycle of fetch 0x10 → no `inst_valid`. Next `addr`=0x20 is accepted the cycle after and completes normally.
- `addr`=0x0000_0006 → `misalign`=1, `inst`=0, `inst_valid`=1 one cycle after accept. `stallreq` high 1 cycle.
- `rst` asserted asynchronously mid-BUSY → all outputs 0 before the next edge. After release with `ce`=1, the fetch restarts from IDLE.
- Loader writes word 5 with 0xAAAA_5555 on the same edge the store reads word 5 → returns the old value. A re-fetch of 0x14 returns 0xAAAA_5555.
